// File: rtl/image_pkg.sv
// Shared constants and types for the frame store: frame geometry, RGB pixel layout
// and the LOAD/PROC/DUMP phase encoding.
package image_pkg;
  localparam int ROWS  = 64;
  localparam int COLS  = 64;
  localparam int RW    = 6;
  localparam int CW    = 6;
  localparam int PIX_W = 24;
  localparam int AW    = RW + CW;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  typedef enum logic [1:0] {
    LOAD,
    PROC,
    DUMP
  } store_state_t;
endpackage

// File: rtl/frame_ram.sv
// Frame memory, one sync read + one sync write port, read latency 1, no backpressure.
// A read and a write to the same address in one cycle return the written data.
module frame_ram
  import image_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  pixel_t        wdata_i,
  input  logic [AW-1:0] raddr_i,
  output pixel_t        rdata_o
);
  // Sized to the whole {row,col} space so non-power-of-2 frames still map uniquely.
  localparam int DEPTH = 1 << AW;

  pixel_t mem [DEPTH];
  pixel_t rd_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_q <= '0;
    end else if (we_i && (waddr_i == raddr_i)) begin
      rd_q <= wdata_i;
    end else begin
      rd_q <= mem[raddr_i];
    end
  end

  assign rdata_o = rd_q;
endmodule

// File: rtl/image_frame_store.sv
// Frame store: raster load stream, engine row/col access (read latency 1), raster dump stream.
// Dump output holds while dump_ready is low; 1 pixel/cycle when dump_ready stays high.
module image_frame_store
  import image_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_valid,
  input  logic [PIX_W-1:0] ld_pix,
  output logic             ld_ready,
  output logic             proc_start,
  input  logic [RW-1:0]    row,
  input  logic [CW-1:0]    col,
  output logic [PIX_W-1:0] in_pix,
  input  logic [PIX_W-1:0] out_pix,
  input  logic             out_we,
  input  logic             proc_done,
  output logic             dump_valid,
  output logic [PIX_W-1:0] dump_pix,
  input  logic             dump_ready,
  output logic             dump_last
);
  localparam logic [RW-1:0] R_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] C_LAST = CW'(COLS - 1);

  store_state_t  state_q, state_d;
  logic [RW-1:0] r_q, r_d, r_nxt;
  logic [CW-1:0] c_q, c_d, c_nxt;
  logic          proc_start_q, proc_start_d;
  logic          dump_valid_q, dump_valid_d;
  logic          at_last, ld_fire, dump_fire;
  logic          ram_we;
  logic [AW-1:0] ram_waddr, ram_raddr;
  pixel_t        ram_wdata, rd_pix;

  assign ld_ready  = (state_q == LOAD) && !rst;
  assign ld_fire   = ld_valid && ld_ready;
  assign dump_fire = dump_valid_q && dump_ready;
  assign at_last   = (r_q == R_LAST) && (c_q == C_LAST);

  // Shared raster counter: load position in LOAD, presented-pixel position in DUMP.
  always_comb begin
    r_nxt = r_q;
    c_nxt = c_q + CW'(1);
    if (c_q == C_LAST) begin
      c_nxt = '0;
      r_nxt = (r_q == R_LAST) ? '0 : r_q + RW'(1);
    end
  end

  always_comb begin
    state_d      = state_q;
    r_d          = r_q;
    c_d          = c_q;
    proc_start_d = 1'b0;
    dump_valid_d = 1'b0;
    ram_we       = 1'b0;
    ram_waddr    = {row, col};
    ram_wdata    = out_pix;
    ram_raddr    = {row, col};
    case (state_q)
      LOAD: begin
        if (ld_fire) begin
          ram_we    = 1'b1;
          ram_waddr = {r_q, c_q};
          ram_wdata = ld_pix;
          r_d       = r_nxt;
          c_d       = c_nxt;
          if (at_last) begin
            state_d      = PROC;
            proc_start_d = 1'b1;
          end
        end
      end
      PROC: begin
        ram_we = out_we;
        if (proc_done) begin
          state_d = DUMP;
        end
      end
      DUMP: begin
        // Read ahead: fetch the pixel that will be presented next cycle.
        dump_valid_d = 1'b1;
        ram_raddr    = {r_q, c_q};
        if (dump_fire) begin
          r_d       = r_nxt;
          c_d       = c_nxt;
          ram_raddr = {r_nxt, c_nxt};
          if (at_last) begin
            state_d      = LOAD;
            dump_valid_d = 1'b0;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= LOAD;
      r_q          <= '0;
      c_q          <= '0;
      proc_start_q <= 1'b0;
      dump_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      r_q          <= r_d;
      c_q          <= c_d;
      proc_start_q <= proc_start_d;
      dump_valid_q <= dump_valid_d;
    end
  end

  frame_ram u_ram (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (ram_we && !rst),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (ram_raddr),
    .rdata_o (rd_pix)
  );

  assign proc_start = proc_start_q;
  assign in_pix     = rd_pix;
  assign dump_valid = dump_valid_q;
  assign dump_pix   = dump_valid_q ? rd_pix : '0;
  assign dump_last  = dump_valid_q && at_last;
endmodule
